// File: rtl/pll_reset_sequencer_pkg.sv
// ------------------------------------------------------------------
// pll_reset_sequencer_pkg : state type, widths and helpers for the sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package pll_reset_sequencer_pkg;

  `include "pll_reset_sequencer_defs.vh"

  typedef enum logic [2:0] {
    ST_PLL_RST   = S_PLL_RST,
    ST_WAIT_LOCK = S_WAIT_LOCK,
    ST_STABLE    = S_STABLE,
    ST_RELEASE   = S_RELEASE,
    ST_RUN       = S_RUN
  } state_e;

  localparam int IDX_W   = 3;
  localparam int RETRY_W = 8;

  function automatic logic [RETRY_W-1:0] sat_inc8(input logic [RETRY_W-1:0] v);
    return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_reset_sequencer_if.sv
// ------------------------------------------------------------------
// pll_reset_sequencer_if : PLL control and domain-reset signals of the sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface pll_reset_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);

  logic                   locked_async;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] dom_rst;
  logic                   ready;
  logic                   lost_lock;
  logic [7:0]             retries;
  logic [2:0]             state_o;

  modport master (
    input  locked_async,
    output pll_rst,
    output dom_rst,
    output ready,
    output lost_lock,
    output retries,
    output state_o
  );

  modport slave (
    output locked_async,
    input  pll_rst,
    input  dom_rst,
    input  ready,
    input  lost_lock,
    input  retries,
    input  state_o
  );

endinterface

`default_nettype wire

// File: rtl/bit_sync_2ff.sv
// ------------------------------------------------------------------
// bit_sync_2ff : two-flop synchroniser, synchronous reset to 0
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module bit_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer_defs.vh
// ------------------------------------------------------------------
// pll_reset_sequencer_defs : 3-bit state encodings shared by RTL and bench
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

localparam logic [2:0] S_PLL_RST   = 3'd0;
localparam logic [2:0] S_WAIT_LOCK = 3'd1;
localparam logic [2:0] S_STABLE    = 3'd2;
localparam logic [2:0] S_RELEASE   = 3'd3;
localparam logic [2:0] S_RUN       = 3'd4;

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ------------------------------------------------------------------
// pll_reset_sequencer : PLL reset/retry, lock qualification, staged domain release
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RELEASE_GAP    = 64,
  parameter int CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  pll_reset_sequencer_if.master    bus
);

  localparam logic [CNT_W-1:0] c_PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST = CNT_W'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

  state_e                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_pll_rst;
  logic [NUM_DOMAINS-1:0] r_dom_rst;
  logic                   r_ready;
  logic                   r_lost_lock;
  logic [RETRY_W-1:0]     r_retries;

  state_e                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic                   w_pll_rst_nxt;
  logic [NUM_DOMAINS-1:0] w_dom_rst_nxt;
  logic                   w_ready_nxt;
  logic                   w_lost_lock_nxt;
  logic [RETRY_W-1:0]     w_retries_nxt;
  logic                   w_locked_s;

  bit_sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.locked_async),
    .o_q (w_locked_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_PLL_RST;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pll_rst   <= 1'b1;
      r_dom_rst   <= '1;
      r_ready     <= 1'b0;
      r_lost_lock <= 1'b0;
      r_retries   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_pll_rst   <= w_pll_rst_nxt;
      r_dom_rst   <= w_dom_rst_nxt;
      r_ready     <= w_ready_nxt;
      r_lost_lock <= w_lost_lock_nxt;
      r_retries   <= w_retries_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + CNT_W'(1);
    w_idx_nxt       = r_idx;
    w_dom_rst_nxt   = r_dom_rst;
    w_ready_nxt     = r_ready;
    w_lost_lock_nxt = 1'b0;
    w_retries_nxt   = r_retries;

    case (r_state)
      ST_PLL_RST: begin
        if (r_cnt == c_PLL_LAST) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (w_locked_s) begin
          w_state_nxt = ST_STABLE;
        end else if (r_cnt == c_TO_LAST) begin
          w_state_nxt   = ST_PLL_RST;
          w_retries_nxt = sat_inc8(r_retries);
        end
      end
      ST_STABLE: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_cnt == c_STB_LAST) begin
          w_state_nxt      = ST_RELEASE;
          w_idx_nxt        = '0;
          w_dom_rst_nxt[0] = 1'b0;
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt     = ST_WAIT_LOCK;
          w_dom_rst_nxt   = '1;
          w_ready_nxt     = 1'b0;
          w_lost_lock_nxt = 1'b1;
          w_idx_nxt       = '0;
        end else if (r_state == ST_RUN) begin
          w_cnt_nxt = r_cnt;
        end else if (r_idx == c_IDX_LAST) begin
          w_state_nxt = ST_RUN;
          w_ready_nxt = 1'b1;
        end else if (r_cnt == c_GAP_LAST) begin
          w_idx_nxt = r_idx + IDX_W'(1);
          w_cnt_nxt = '0;
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (i == int'(r_idx) + 1) w_dom_rst_nxt[i] = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_PLL_RST;
      end
    endcase

    if (w_state_nxt != r_state) w_cnt_nxt = '0;
    w_pll_rst_nxt = (w_state_nxt == ST_PLL_RST);
  end

  assign bus.pll_rst   = r_pll_rst;
  assign bus.dom_rst   = r_dom_rst;
  assign bus.ready     = r_ready;
  assign bus.lost_lock = r_lost_lock;
  assign bus.retries   = r_retries;
  assign bus.state_o   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ------------------------------------------------------------------
// tb_pll_reset_sequencer : scenario tasks plus randomized run against a reference model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_pll_reset_sequencer;

  `include "pll_reset_sequencer_defs.vh"

  localparam int ND  = 3;
  localparam int PRC = 4;
  localparam int LT  = 20;
  localparam int SC  = 8;
  localparam int RG  = 3;
  localparam int CW  = 16;
  localparam int OW  = ND + 14;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pll_reset_sequencer_if #(.NUM_DOMAINS(ND)) bus ();

  pll_reset_sequencer #(
    .NUM_DOMAINS    (ND),
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (LT),
    .STABLE_CYCLES  (SC),
    .RELEASE_GAP    (RG),
    .CNT_W          (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: current phase, cycles spent in it, retry count, sync pipe
  int m_state = 0;
  int m_t     = 0;
  int m_ret   = 0;
  bit m_lost  = 1'b0;
  bit s0      = 1'b0;
  bit s1      = 1'b0;

  logic [OW-1:0] w_obs;
  assign w_obs = {bus.pll_rst, bus.dom_rst, bus.ready, bus.lost_lock, bus.retries, bus.state_o};

  function automatic logic [OW-1:0] m_exp();
    int rel;
    logic [ND-1:0] dom;
    dom = '1;
    if (m_state == int'(S_RELEASE)) begin
      rel = 1 + m_t / RG;
      if (rel > ND) rel = ND;
      for (int i = 0; i < rel; i++) dom[i] = 1'b0;
    end else if (m_state == int'(S_RUN)) begin
      dom = '0;
    end
    return {(m_state == int'(S_PLL_RST)), dom, (m_state == int'(S_RUN)), m_lost,
            8'(m_ret), 3'(m_state)};
  endfunction

  function automatic void m_step(input logic r, input logic l);
    int nxt;
    bit ls;
    if (r) begin
      m_state = S_PLL_RST; m_t = 0; m_ret = 0; m_lost = 0; s0 = 0; s1 = 0;
    end else begin
      ls = s1; s1 = s0; s0 = l; m_lost = 0; nxt = m_state;
      if (m_state == int'(S_PLL_RST)) begin
        if (m_t == PRC - 1) nxt = S_WAIT_LOCK;
      end else if (m_state == int'(S_WAIT_LOCK)) begin
        if (ls) nxt = S_STABLE;
        else if (m_t == LT - 1) begin
          nxt = S_PLL_RST;
          if (m_ret < 255) m_ret++;
        end
      end else if (m_state == int'(S_STABLE)) begin
        if (!ls) nxt = S_WAIT_LOCK;
        else if (m_t == SC - 1) nxt = S_RELEASE;
      end else begin
        if (!ls) begin
          nxt = S_WAIT_LOCK;
          m_lost = 1;
        end else if (m_state == int'(S_RELEASE) && m_t == (ND - 1) * RG) begin
          nxt = S_RUN;
        end
      end
      m_t = (nxt == m_state) ? m_t + 1 : 0;
      m_state = nxt;
    end
  endfunction

  task automatic tick(input logic r, input logic l);
    rst = r;
    bus.locked_async = l;
    @(posedge clk);
    m_step(r, l);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    n_chk++;
    if (bus.pll_rst !== 1'b1 || bus.dom_rst !== 3'b111 || bus.ready !== 1'b0 ||
        bus.lost_lock !== 1'b0 || bus.retries !== 8'd0 || bus.state_o !== S_PLL_RST)
      $display("FAIL reset_values got=%h exp pll=1 dom=111 rdy=0 lost=0 ret=0 st=0", w_obs);
    else n_pass++;
  endtask

  task automatic test_power_up();
    int pll_hi = 1;
    logic [ND-1:0] prev = 3'b111;
    logic [ND-1:0] seq [4];
    int tc [4];
    int nchg = 0;
    for (int i = 1; i <= 60; i++) begin
      tick(1'b0, 1'b1);
      n_chk++;
      if (w_obs !== m_exp()) $display("FAIL model_powerup cyc=%0d got=%h exp=%h", cyc, w_obs, m_exp());
      else n_pass++;
      if (bus.pll_rst === 1'b1) pll_hi++;
      if (bus.dom_rst !== prev && nchg < 4) begin
        seq[nchg] = bus.dom_rst; tc[nchg] = i; nchg++;
      end
      prev = bus.dom_rst;
    end
    n_chk++;
    if (pll_hi != 4) $display("FAIL powerup_pll_width got=%0d exp=4", pll_hi);
    else n_pass++;
    n_chk++;
    if (nchg != 3 || seq[0] !== 3'b110 || seq[1] !== 3'b100 || seq[2] !== 3'b000)
      $display("FAIL powerup_dom_seq got_n=%0d %b %b %b exp 110 100 000", nchg, seq[0], seq[1], seq[2]);
    else n_pass++;
    n_chk++;
    if (nchg < 3 || tc[1] - tc[0] != 3 || tc[2] - tc[1] != 3)
      $display("FAIL powerup_dom_gap got=%0d,%0d exp=3,3", tc[1] - tc[0], tc[2] - tc[1]);
    else n_pass++;
    n_chk++;
    if (bus.ready !== 1'b1 || bus.retries !== 8'd0)
      $display("FAIL powerup_ready got rdy=%b ret=%0d exp rdy=1 ret=0", bus.ready, bus.retries);
    else n_pass++;
  endtask

  task automatic test_no_lock();
    int rises = 0;
    int last_rise = -1;
    int falls = 0;
    logic prev_pll = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 6300; i++) begin
      tick(1'b0, 1'b0);
      n_chk++;
      if (w_obs !== m_exp()) $display("FAIL model_nolock cyc=%0d got=%h exp=%h", cyc, w_obs, m_exp());
      else n_pass++;
      if (bus.pll_rst === 1'b1 && prev_pll === 1'b0) begin
        rises++;
        if (rises <= 4) begin
          n_chk++;
          if (bus.retries !== 8'(rises)) $display("FAIL nolock_retry_count got=%0d exp=%0d", bus.retries, rises);
          else n_pass++;
          if (rises >= 2) begin
            n_chk++;
            if (i - last_rise != 24) $display("FAIL nolock_period got=%0d exp=24", i - last_rise);
            else n_pass++;
          end
        end
        last_rise = i;
      end
      if (bus.pll_rst === 1'b0 && prev_pll === 1'b1 && rises > 0 && falls < 3) begin
        falls++;
        n_chk++;
        if (i - last_rise != 4) $display("FAIL nolock_pulse_width got=%0d exp=4", i - last_rise);
        else n_pass++;
      end
      prev_pll = bus.pll_rst;
    end
    n_chk++;
    if (bus.retries !== 8'd255) $display("FAIL nolock_saturate got=%0d exp=255", bus.retries);
    else n_pass++;
  endtask

  task automatic test_stable_glitch();
    int ret0;
    bit found = 0;
    bit bad_dom = 0;
    bit bad_lost = 0;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1'b0, 1'b1);
      if (bus.state_o === S_STABLE) found = 1;
    end
    n_chk++;
    if (!found) $display("FAIL glitch_reach_stable got=timeout exp=state 2");
    else n_pass++;
    ret0 = int'(bus.retries);
    for (int j = 1; j <= 10; j++) begin
      tick(1'b0, (j == 4) ? 1'b0 : 1'b1);
      n_chk++;
      if (w_obs !== m_exp()) $display("FAIL model_glitch cyc=%0d got=%h exp=%h", cyc, w_obs, m_exp());
      else n_pass++;
      if (bus.dom_rst !== 3'b111) bad_dom = 1;
      if (bus.lost_lock !== 1'b0) bad_lost = 1;
      if (j == 5 || j == 6) begin
        n_chk++;
        if (bus.state_o !== ((j == 5) ? S_STABLE : S_WAIT_LOCK))
          $display("FAIL glitch_state j=%0d got=%0d exp=%0d", j, bus.state_o, (j == 5) ? 2 : 1);
        else n_pass++;
      end
    end
    n_chk++;
    if (bad_dom || bad_lost || int'(bus.retries) != ret0)
      $display("FAIL glitch_side_effects got dom_bad=%0d lost_bad=%0d ret=%0d exp 0 0 %0d",
               bad_dom, bad_lost, bus.retries, ret0);
    else n_pass++;
  endtask

  task automatic test_run_drop();
    bit found = 0;
    int pulses = 0;
    bit pll_seen = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1'b0, 1'b1);
      if (bus.ready === 1'b1) found = 1;
    end
    n_chk++;
    if (!found) $display("FAIL rundrop_reach_ready got=timeout exp=ready 1");
    else n_pass++;
    for (int j = 1; j <= 40; j++) begin
      tick(1'b0, (j == 1) ? 1'b0 : 1'b1);
      n_chk++;
      if (w_obs !== m_exp()) $display("FAIL model_rundrop cyc=%0d got=%h exp=%h", cyc, w_obs, m_exp());
      else n_pass++;
      if (bus.lost_lock === 1'b1) pulses++;
      if (bus.pll_rst === 1'b1) pll_seen = 1;
      if (j == 2) begin
        n_chk++;
        if (bus.ready !== 1'b1 || bus.dom_rst !== 3'b000)
          $display("FAIL rundrop_before got rdy=%b dom=%b exp 1 000", bus.ready, bus.dom_rst);
        else n_pass++;
      end
      if (j == 3) begin
        n_chk++;
        if (bus.ready !== 1'b0 || bus.dom_rst !== 3'b111 || bus.lost_lock !== 1'b1 || bus.state_o !== S_WAIT_LOCK)
          $display("FAIL rundrop_after got rdy=%b dom=%b lost=%b st=%0d exp 0 111 1 1",
                   bus.ready, bus.dom_rst, bus.lost_lock, bus.state_o);
        else n_pass++;
      end
    end
    n_chk++;
    if (pulses != 1 || pll_seen || bus.ready !== 1'b1)
      $display("FAIL rundrop_recover got pulses=%0d pll=%0d rdy=%b exp 1 0 1", pulses, pll_seen, bus.ready);
    else n_pass++;
  endtask

  task automatic test_release_drop();
    bit found = 0;
    bit pll_seen = 0;
    int ret0;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1'b0, 1'b1);
      if (bus.dom_rst === 3'b110) found = 1;
    end
    n_chk++;
    if (!found) $display("FAIL reldrop_reach_110 got=timeout exp=dom 110");
    else n_pass++;
    ret0 = int'(bus.retries);
    for (int j = 1; j <= 30; j++) begin
      tick(1'b0, (j <= 20) ? 1'b0 : 1'b1);
      n_chk++;
      if (w_obs !== m_exp()) $display("FAIL model_reldrop cyc=%0d got=%h exp=%h", cyc, w_obs, m_exp());
      else n_pass++;
      if (bus.pll_rst === 1'b1) pll_seen = 1;
      if (j == 3) begin
        n_chk++;
        if (bus.dom_rst !== 3'b111 || bus.state_o !== S_WAIT_LOCK || bus.lost_lock !== 1'b1)
          $display("FAIL reldrop_reassert got dom=%b st=%0d lost=%b exp 111 1 1",
                   bus.dom_rst, bus.state_o, bus.lost_lock);
        else n_pass++;
      end
      if (j == 23) begin
        n_chk++;
        if (bus.state_o !== S_STABLE || int'(bus.retries) != ret0)
          $display("FAIL reldrop_lock_vs_timeout got st=%0d ret=%0d exp 2 %0d", bus.state_o, bus.retries, ret0);
        else n_pass++;
      end
    end
    n_chk++;
    if (pll_seen) $display("FAIL reldrop_pll_rst got=1 exp=0");
    else n_pass++;
  endtask

  task automatic test_rst_in_run();
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1'b0, 1'b1);
      if (bus.ready === 1'b1) found = 1;
    end
    n_chk++;
    if (!found) $display("FAIL rstrun_reach_ready got=timeout exp=ready 1");
    else n_pass++;
    tick(1'b1, 1'b1);
    n_chk++;
    if (bus.pll_rst !== 1'b1 || bus.dom_rst !== 3'b111 || bus.ready !== 1'b0 ||
        bus.lost_lock !== 1'b0 || bus.retries !== 8'd0 || bus.state_o !== S_PLL_RST)
      $display("FAIL rstrun_values got=%h exp pll=1 dom=111 rdy=0 lost=0 ret=0 st=0", w_obs);
    else n_pass++;
    for (int j = 1; j <= 25; j++) begin
      tick(1'b0, 1'b1);
      n_chk++;
      if (w_obs !== m_exp()) $display("FAIL model_rstrun cyc=%0d got=%h exp=%h", cyc, w_obs, m_exp());
      else n_pass++;
      if (j == 3 || j == 4) begin
        n_chk++;
        if (bus.pll_rst !== ((j == 3) ? 1'b1 : 1'b0))
          $display("FAIL rstrun_restart j=%0d got=%b exp=%b", j, bus.pll_rst, j == 3);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int run_left = 0;
    logic lvl = 1'b1;
    logic r;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 2500; i++) begin
      if (run_left == 0) begin
        lvl = ($urandom_range(0, 3) != 0);
        run_left = $urandom_range(1, 30);
      end
      run_left--;
      r = ($urandom_range(0, 299) == 0);
      tick(r, lvl);
      n_chk++;
      if (w_obs !== m_exp()) $display("FAIL model_random cyc=%0d got=%h exp=%h", cyc, w_obs, m_exp());
      else n_pass++;
    end
  endtask

  initial begin
    bus.locked_async = 1'b0;
    test_reset();
    test_power_up();
    test_no_lock();
    test_stable_glitch();
    test_run_drop();
    test_release_drop();
    test_rst_in_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
